// File: rtl/fft_io_controller_pkg.sv
// Shared definitions for the FFT I/O path: state encoding, address width
// derivation and the bit-reverse helper also used by the butterfly address
// generator.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_REQ     = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_UNLOAD  = 2'd3
  } state_t;

  // Widest address the bit-reverse helper handles (N up to 65536).
  localparam int MAX_ADDR_W = 16;

  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

  // Mirrors the w LSBs of v; bits at and above w come back as zero.
  function automatic logic [MAX_ADDR_W-1:0] bit_rev(input logic [MAX_ADDR_W-1:0] v,
                                                    input int w);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_ADDR_W; b++) begin
      if (b < w) r[b] = v[w-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_io_controller_if.sv
// Bundle of the sample streams, sample-RAM port and fftDriver handshake seen
// by the I/O controller. master = controller side, slave = surrounding logic.
interface fft_io_controller_if
  import fft_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              io_bank;
  logic              input_valid;
  logic              io_busy;
  logic              fft_busy;
  logic              fft_done;
  logic              bank_select;

  modport master (
    input  s_data, s_valid, m_ready, mem_rdata, fft_busy, fft_done, bank_select,
    output s_ready, m_data, m_valid, m_last, mem_we, mem_waddr, mem_wdata,
           mem_re, mem_raddr, io_bank, input_valid, io_busy
  );

  modport slave (
    output s_data, s_valid, m_ready, mem_rdata, fft_busy, fft_done, bank_select,
    input  s_ready, m_data, m_valid, m_last, mem_we, mem_waddr, mem_wdata,
           mem_re, mem_raddr, io_bank, input_valid, io_busy
  );
endinterface

// File: rtl/fft_io_controller_skid_fifo.sv
// Two-entry output skid FIFO; count is exported so the reader can issue RAM
// reads only when the in-flight data is guaranteed a slot.
module fft_skid_fifo
  import fft_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 2'd1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 2'd1;
    end
  end

  // Storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
endmodule

// File: rtl/fft_io_controller.sv
// Host-side I/O sequencer for the in-place FFT: loads a frame into the sample
// RAM, hands it to fftDriver, then drains results with full backpressure.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ST_LOAD    | accepting input beats, writing RAM (bit-reversed if enabled)
//  ST_REQ     | frame loaded, input_valid high until fftDriver reports busy
//  ST_COMPUTE | fftDriver owns RAM, waiting for fft_done
//  ST_UNLOAD  | reading RAM in natural order into the skid FIFO / out stream
module fft_io_controller
  import fft_pkg::*;
#(
  parameter int N         = 32,
  parameter int DATA_W    = 32,
  parameter int BITREV_IN = 1,
  localparam int ADDR_W   = addr_width(N)
) (
  input  logic                clk,
  input  logic                reset,
  fft_io_controller_if.master bus
);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N - 1);
  localparam logic [ADDR_W:0] NUM_IDX  = (ADDR_W+1)'(N);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W:0]     r_wr_idx;
  logic [ADDR_W:0]     r_rd_idx;
  logic                r_inflight;
  logic                r_inflight_last;
  logic                r_io_bank;
  logic                w_s_ready;
  logic                w_io_busy;
  logic                w_input_valid;
  logic                w_mem_we;
  logic                w_mem_re;
  logic                w_fifo_raw_valid;
  logic                w_fifo_valid;
  logic [DATA_W:0]     w_head;
  logic                w_head_last;
  logic [1:0]          w_fifo_count;
  logic                w_pop;
  logic [2:0]          w_occ;
  logic                w_credit;
  logic                w_unload_done;
  logic [ADDR_W-1:0]   w_waddr_rev;

  assign w_waddr_rev = ADDR_W'(bit_rev(MAX_ADDR_W'(r_wr_idx[ADDR_W-1:0]), ADDR_W));

  // Outputs are forced to their reset values while reset is held.
  assign w_fifo_valid  = w_fifo_raw_valid && !reset;
  assign w_head_last   = w_head[DATA_W];
  assign w_pop         = w_fifo_valid && bus.m_ready;
  // Slots claimed after this cycle: stored + in flight - leaving; a new read
  // is allowed only if that leaves room for it.
  assign w_occ         = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_credit      = (w_occ < 3'd2);
  assign w_unload_done = (r_state == ST_UNLOAD) && w_pop && w_head_last;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_state_next;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_next  = r_state;
    w_s_ready     = 1'b0;
    w_io_busy     = 1'b1;
    w_input_valid = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_re      = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_LOAD: begin
          w_s_ready = 1'b1;
          w_mem_we  = bus.s_valid;
          if (bus.s_valid && (r_wr_idx == LAST_IDX)) w_state_next = ST_REQ;
        end
        ST_REQ: begin
          w_io_busy     = 1'b0;
          w_input_valid = 1'b1;
          if (bus.fft_busy) w_state_next = ST_COMPUTE;
        end
        ST_COMPUTE: begin
          w_io_busy = 1'b0;
          if (bus.fft_done) w_state_next = ST_UNLOAD;
        end
        ST_UNLOAD: begin
          w_mem_re = w_credit && (r_rd_idx != NUM_IDX);
          if (w_unload_done) w_state_next = ST_LOAD;
        end
        default: w_state_next = ST_LOAD;
      endcase
    end
  end

  // Sample counters, read pipeline tracking and I/O bank capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx        <= '0;
      r_rd_idx        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_io_bank       <= 1'b0;
    end else begin
      r_inflight      <= w_mem_re;
      r_inflight_last <= (r_rd_idx == LAST_IDX);
      if (w_mem_we) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_mem_re) r_rd_idx <= r_rd_idx + 1'b1;
      if ((r_state == ST_COMPUTE) && bus.fft_done) r_io_bank <= bus.bank_select;
      if (w_unload_done) begin
        r_wr_idx <= '0;
        r_rd_idx <= '0;
      end
    end
  end

  fft_skid_fifo #(.W(DATA_W + 1)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, bus.mem_rdata}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_raw_valid),
    .o_count (w_fifo_count)
  );

  assign bus.s_ready     = w_s_ready;
  assign bus.io_busy     = w_io_busy;
  assign bus.input_valid = w_input_valid;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_waddr   = (BITREV_IN != 0) ? w_waddr_rev : r_wr_idx[ADDR_W-1:0];
  assign bus.mem_wdata   = bus.s_data;
  assign bus.mem_re      = w_mem_re;
  assign bus.mem_raddr   = r_rd_idx[ADDR_W-1:0];
  assign bus.io_bank     = r_io_bank;
  assign bus.m_valid     = w_fifo_valid;
  assign bus.m_data      = w_head[DATA_W-1:0];
  assign bus.m_last      = w_fifo_valid && w_head_last;
endmodule

// File: tb/tb_fft_io_controller.sv
// Directed + randomized bench for fft_io_controller with N=8: a 1-cycle RAM
// model, fftDriver handshake driven by hand, and a frame-level reference of
// the expected write addresses and output order.
module tb_fft_io_controller;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_io_controller_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  fft_io_controller_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  fft_io_controller #(.N(N), .DATA_W(DW), .BITREV_IN(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));
  fft_io_controller #(.N(N), .DATA_W(DW), .BITREV_IN(0)) dut_nat (
    .clk(clk), .reset(reset), .bus(bus2.master));

  int checks = 0;
  int fails  = 0;
  logic [DW-1:0] ram [N];
  logic [DW-1:0] pl_vals [N];
  logic [DW-1:0] din [N];
  logic [DW-1:0] expq [N];
  logic pl_req = 1'b0;
  int re_cnt = 0;
  int re_base = 0;

  // Sample RAM: synchronous write, read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (pl_req) for (int k = 0; k < N; k++) ram[k] <= pl_vals[k];
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_re) begin
      bus.mem_rdata <= ram[bus.mem_raddr];
      re_cnt <= re_cnt + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      bus.s_data  = din[i];
      bus.s_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("ld_ready[%0d]", i), bus.s_ready, 1'b1);
      chk($sformatf("ld_we[%0d]", i), bus.mem_we, 1'b1);
      chk($sformatf("ld_waddr[%0d]", i), bus.mem_waddr, rev3(i));
      chk($sformatf("ld_wdata[%0d]", i), bus.mem_wdata, din[i]);
      nxt();
    end
    bus.s_valid = 1'b0;
  endtask

  // mode 0: m_ready high; 1: 1,0,0,1,0,1 then random; 2: toggles every cycle
  task automatic drain(input int mode);
    int beats = 0;
    int cyc = 0;
    logic pv = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [5:0] pat = 6'b101001;
    while (beats < N && cyc < 200) begin
      if (mode == 0)      bus.m_ready = 1'b1;
      else if (mode == 1) bus.m_ready = (cyc < 6) ? pat[cyc] : 1'($urandom);
      else                bus.m_ready = 1'(cyc % 2);
      @(negedge clk);
      if (pv) begin
        chk("hold_valid", bus.m_valid, 1'b1);
        chk("hold_data", bus.m_data, pd);
      end
      if (mode == 0) chk("stream_valid", bus.m_valid, 1'b1);
      if (bus.m_valid && bus.m_ready) begin
        chk($sformatf("out_data[%0d]", beats), bus.m_data, expq[beats]);
        chk($sformatf("out_last[%0d]", beats), bus.m_last, (beats == N - 1));
        beats++;
        pv = 1'b0;
      end else begin
        pv = bus.m_valid;
      end
      pd = bus.m_data;
      cyc++;
      nxt();
    end
    chk("beat_count", beats, N);
    bus.m_ready = 1'b0;
  endtask

  task automatic after_unload(input logic bank);
    @(negedge clk);
    chk("post_ready", bus.s_ready, 1'b1);
    chk("post_mvalid", bus.m_valid, 1'b0);
    chk("post_busy", bus.io_busy, 1'b1);
    chk("post_bank", bus.io_bank, bank);
    chk("read_count", re_cnt - re_base, N);
    nxt();
  endtask

  initial begin
    bus.s_data = '0; bus.s_valid = 1'b1; bus.m_ready = 1'b0;
    bus.fft_busy = 1'b0; bus.fft_done = 1'b0; bus.bank_select = 1'b0;
    bus2.s_data = '0; bus2.s_valid = 1'b0; bus2.m_ready = 1'b0;
    bus2.fft_busy = 1'b0; bus2.fft_done = 1'b0; bus2.bank_select = 1'b0;
    bus2.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_last", bus.m_last, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_re", bus.mem_re, 1'b0);
    chk("rst_input_valid", bus.input_valid, 1'b0);
    chk("rst_io_bank", bus.io_bank, 1'b0);
    chk("rst_io_busy", bus.io_busy, 1'b1);
    nxt();
    reset = 1'b0;
    bus.s_valid = 1'b0;

    // Frame 1: load 0..7, held REQ handshake, preloaded RAM, streaming unload
    for (int i = 0; i < N; i++) din[i] = DW'(i);
    load(0, N);
    @(negedge clk);
    chk("req_iv", bus.input_valid, 1'b1);
    chk("req_busy", bus.io_busy, 1'b0);
    chk("req_ready", bus.s_ready, 1'b0);
    for (int c = 0; c < 5; c++) begin
      nxt();
      bus.s_valid = 1'b1;
      bus.s_data  = $urandom;
      @(negedge clk);
      chk("hold_iv", bus.input_valid, 1'b1);
      chk("hold_busy", bus.io_busy, 1'b0);
      chk("req_no_we", bus.mem_we, 1'b0);
    end
    nxt();
    bus.s_valid  = 1'b0;
    bus.fft_busy = 1'b1;
    @(negedge clk);
    chk("busy_seen_iv", bus.input_valid, 1'b1);
    nxt();
    @(negedge clk);
    chk("comp_iv", bus.input_valid, 1'b0);
    chk("comp_busy", bus.io_busy, 1'b0);
    for (int k = 0; k < N; k++) begin
      pl_vals[k] = DW'(100 + k);
      expq[k]    = DW'(100 + k);
    end
    nxt();
    pl_req = 1'b1;
    @(negedge clk);
    chk("comp_no_re", bus.mem_re, 1'b0);
    nxt();
    pl_req = 1'b0;
    re_base = re_cnt;
    bus.bank_select = 1'b1;
    bus.m_ready = 1'b1;
    bus.fft_done = 1'b1;
    bus.fft_busy = 1'b0;
    nxt();
    bus.fft_done = 1'b0;
    @(negedge clk);
    chk("lat_re", bus.mem_re, 1'b1);
    chk("lat_valid0", bus.m_valid, 1'b0);
    chk("unload_bank", bus.io_bank, 1'b1);
    chk("unload_busy", bus.io_busy, 1'b1);
    nxt();
    @(negedge clk);
    chk("lat_valid1", bus.m_valid, 1'b0);
    nxt();
    drain(0);
    after_unload(1'b1);

    // Frame 2: random data, spurious fft_done in LOAD and REQ, backpressure
    for (int i = 0; i < N; i++) din[i] = $urandom;
    for (int i = 0; i < N; i++) expq[rev3(i)] = din[i];
    bus.bank_select = 1'b0;
    load(0, 4);
    bus.fft_done = 1'b1;
    @(negedge clk);
    chk("spur_load_ready", bus.s_ready, 1'b1);
    chk("spur_load_bank", bus.io_bank, 1'b1);
    nxt();
    bus.fft_done = 1'b0;
    load(4, 4);
    bus.fft_done = 1'b1;
    @(negedge clk);
    chk("f2_req_iv", bus.input_valid, 1'b1);
    nxt();
    bus.fft_done = 1'b0;
    @(negedge clk);
    chk("spur_req_iv", bus.input_valid, 1'b1);
    chk("spur_req_busy", bus.io_busy, 1'b0);
    nxt();
    bus.fft_busy = 1'b1;
    nxt();
    re_base = re_cnt;
    bus.fft_busy = 1'b0;
    bus.fft_done = 1'b1;
    nxt();
    bus.fft_done = 1'b0;
    drain(1);
    after_unload(1'b0);

    // Reset after 3 accepted beats, then a full frame with toggling m_ready
    for (int i = 0; i < N; i++) din[i] = $urandom;
    load(0, 3);
    reset = 1'b1;
    bus.s_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", bus.s_ready, 1'b0);
    chk("mid_rst_we", bus.mem_we, 1'b0);
    chk("mid_rst_busy", bus.io_busy, 1'b1);
    chk("mid_rst_iv", bus.input_valid, 1'b0);
    nxt();
    reset = 1'b0;
    bus.s_valid = 1'b0;
    for (int i = 0; i < N; i++) din[i] = $urandom;
    for (int i = 0; i < N; i++) expq[rev3(i)] = din[i];
    load(0, N);
    bus.fft_busy = 1'b1;
    nxt();
    re_base = re_cnt;
    bus.fft_busy = 1'b0;
    bus.bank_select = 1'b1;
    bus.fft_done = 1'b1;
    nxt();
    bus.fft_done = 1'b0;
    drain(2);
    after_unload(1'b1);

    // Natural-order instance: write addresses follow the sample index
    for (int i = 0; i < N; i++) begin
      bus2.s_data  = $urandom;
      bus2.s_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("nat_we[%0d]", i), bus2.mem_we, 1'b1);
      chk($sformatf("nat_waddr[%0d]", i), bus2.mem_waddr, i);
      nxt();
    end
    bus2.s_valid = 1'b0;
    @(negedge clk);
    chk("nat_iv", bus2.input_valid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
